conversor_bin_bcd_secuencial: RTL and testbench

//  Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).

---
 rtl/conversor_bin_bcd_secuencial.sv | 130 +++++++++++++
 tb/tb_conversor_bin_bcd_secuencial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/conversor_bin_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one binary bit per clock.
// Define SIGNO_EN to treat reg_binario as two's complement and report the sign on negativo.
module conversor_bin_bcd_secuencial #(
  parameter int TAM_REG_BIN = 16,
  parameter int NUM_DIG     = 5,
  parameter int ANCHO_CONT  = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     inicio,
  input  logic [TAM_REG_BIN-1:0]   reg_binario,
  output logic                     ocupado,
  output logic                     valido,
  output logic [4*NUM_DIG-1:0]     reg_BCD,
  output logic                     desborde,
  output logic                     negativo
);

  localparam int ANCHO_ACUM = 4 * NUM_DIG;

  // Handshake: inicio is accepted on a rising edge only while ocupado=0.
  // valido is a one-cycle pulse; reg_BCD/desborde/negativo are held until the next pulse.
  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  estado_t                  estado_q, estado_d;
  logic [TAM_REG_BIN-1:0]   bin_q, bin_d;
  logic [ANCHO_ACUM-1:0]    acum_q, acum_d;
  logic [ANCHO_ACUM-1:0]    acum_corr;
  logic [ANCHO_CONT-1:0]    cont_q, cont_d;
  logic                     ovf_q, ovf_d;
  logic                     neg_pend_q, neg_pend_d;
  logic                     valido_q, valido_d;
  logic [ANCHO_ACUM-1:0]    bcd_q, bcd_d;
  logic                     desborde_q, desborde_d;
  logic                     negativo_q, negativo_d;

  // All digits are corrected from the same pre-shift value; 4-bit wrap on +3.
  always_comb begin
    acum_corr = acum_q;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (acum_q[4*i +: 4] >= 4'd5)
        acum_corr[4*i +: 4] = acum_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    bin_d      = bin_q;
    acum_d     = acum_q;
    cont_d     = cont_q;
    ovf_d      = ovf_q;
    neg_pend_d = neg_pend_q;
    valido_d   = 1'b0;
    bcd_d      = bcd_q;
    desborde_d = desborde_q;
    negativo_d = negativo_q;

    case (estado_q)
      REPOSO: begin
        if (inicio) begin
`ifdef SIGNO_EN
          neg_pend_d = reg_binario[TAM_REG_BIN-1];
          bin_d      = reg_binario[TAM_REG_BIN-1]
                       ? (~reg_binario) + {{(TAM_REG_BIN-1){1'b0}}, 1'b1}
                       : reg_binario;
`else
          neg_pend_d = 1'b0;
          bin_d      = reg_binario;
`endif
          acum_d   = '0;
          cont_d   = ANCHO_CONT'(TAM_REG_BIN);
          ovf_d    = 1'b0;
          estado_d = DESPLAZA;
        end
      end
      DESPLAZA: begin
        {acum_d, bin_d} = {acum_corr[ANCHO_ACUM-2:0], bin_q, 1'b0};
        ovf_d           = ovf_q | acum_corr[ANCHO_ACUM-1];
        cont_d          = cont_q - 1'b1;
        if (cont_q == ANCHO_CONT'(1))
          estado_d = FIN;
      end
      FIN: begin
        bcd_d      = acum_q;
        desborde_d = ovf_q;
        negativo_d = neg_pend_q;
        valido_d   = 1'b1;
        estado_d   = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= REPOSO;
      bin_q      <= '0;
      acum_q     <= '0;
      cont_q     <= '0;
      ovf_q      <= 1'b0;
      neg_pend_q <= 1'b0;
      valido_q   <= 1'b0;
      bcd_q      <= '0;
      desborde_q <= 1'b0;
      negativo_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      bin_q      <= bin_d;
      acum_q     <= acum_d;
      cont_q     <= cont_d;
      ovf_q      <= ovf_d;
      neg_pend_q <= neg_pend_d;
      valido_q   <= valido_d;
      bcd_q      <= bcd_d;
      desborde_q <= desborde_d;
      negativo_q <= negativo_d;
    end
  end

  assign ocupado  = (estado_q != REPOSO);
  assign valido   = valido_q;
  assign reg_BCD  = bcd_q;
  assign desborde = desborde_q;
  assign negativo = negativo_q;

endmodule

// File: tb/tb_conversor_bin_bcd_secuencial.sv
// Directed bench for conversor_bin_bcd_secuencial: a 5-digit and a 4-digit instance
// share the stimulus; table vectors plus hand-written multi-cycle sequences.
module tb_conversor_bin_bcd_secuencial;

  logic        clk;
  logic        reset_n;
  logic        inicio;
  logic [15:0] reg_binario;

  logic        ocupado, valido, desborde, negativo;
  logic [19:0] reg_BCD;
  logic        ocupado4, valido4, desborde4, negativo4;
  logic [15:0] reg_BCD4;

  int errors = 0;
  int checks = 0;

  conversor_bin_bcd_secuencial #(.TAM_REG_BIN(16), .NUM_DIG(5), .ANCHO_CONT(5)) u_dut (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .reg_binario(reg_binario),
    .ocupado(ocupado), .valido(valido), .reg_BCD(reg_BCD),
    .desborde(desborde), .negativo(negativo)
  );

  conversor_bin_bcd_secuencial #(.TAM_REG_BIN(16), .NUM_DIG(4), .ANCHO_CONT(5)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .reg_binario(reg_binario),
    .ocupado(ocupado4), .valido(valido4), .reg_BCD(reg_BCD4),
    .desborde(desborde4), .negativo(negativo4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        neg;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after the accepting edge; counts edges until valido.
  task automatic wait_valido(output int lat, output int ocup);
    lat  = 0;
    ocup = 0;
    if (ocupado) ocup++;
    while (!valido && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ocupado) ocup++;
    end
  endtask

  task automatic start_conv(input logic [15:0] v);
    reg_binario = v;
    inicio      = 1'b1;
    @(posedge clk); #1;
    inicio      = 1'b0;
    reg_binario = 16'($urandom_range(0, 65535));
  endtask

  task automatic check_result(input string name, input logic [19:0] exp_bcd, input logic exp_neg);
    chk({name, "_valido"},   {31'd0, valido},    32'd1);
    chk({name, "_bcd"},      {12'd0, reg_BCD},   {12'd0, exp_bcd});
    chk({name, "_desborde"}, {31'd0, desborde},  32'd0);
    chk({name, "_negativo"}, {31'd0, negativo},  {31'd0, exp_neg});
    chk({name, "_valido4"},  {31'd0, valido4},   32'd1);
    chk({name, "_bcd4"},     {16'd0, reg_BCD4},  {16'd0, exp_bcd[15:0]});
    chk({name, "_desb4"},    {31'd0, desborde4}, {31'd0, (exp_bcd[19:16] != 4'd0)});
  endtask

  task automatic run_conv(input string name, input logic [15:0] v,
                          input logic [19:0] exp_bcd, input logic exp_neg);
    int lat, ocup;
    start_conv(v);
    wait_valido(lat, ocup);
    chk({name, "_latencia"}, lat,  32'd17);
    chk({name, "_ocupado"},  ocup, 32'd17);
    check_result(name, exp_bcd, exp_neg);
    @(posedge clk); #1;
    chk({name, "_pulso"},    {31'd0, valido},  32'd0);
    chk({name, "_retenido"}, {12'd0, reg_BCD}, {12'd0, exp_bcd});
  endtask

  initial begin
    int lat, ocup, nv, lat_at;

`ifdef SIGNO_EN
    tbl.push_back('{16'h8000, 20'h32768, 1'b1});
    tbl.push_back('{16'hFFFF, 20'h00001, 1'b1});
    tbl.push_back('{16'h7FFF, 20'h32767, 1'b0});
    tbl.push_back('{16'd0,    20'h00000, 1'b0});
    tbl.push_back('{16'hFFF6, 20'h00010, 1'b1});
    tbl.push_back('{16'd9999, 20'h09999, 1'b0});
    tbl.push_back('{16'hCFC7, 20'h12345, 1'b1});
`else
    tbl.push_back('{16'hFFFF,  20'h65535, 1'b0});
    tbl.push_back('{16'd0,     20'h00000, 1'b0});
    tbl.push_back('{16'd10,    20'h00010, 1'b0});
    tbl.push_back('{16'd1,     20'h00001, 1'b0});
    tbl.push_back('{16'd100,   20'h00100, 1'b0});
    tbl.push_back('{16'd12345, 20'h12345, 1'b0});
    tbl.push_back('{16'd40000, 20'h40000, 1'b0});
    tbl.push_back('{16'd9999,  20'h09999, 1'b0});
`endif

    reset_n     = 1'b0;
    inicio      = 1'b0;
    reg_binario = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ocupado",  {31'd0, ocupado},  32'd0);
    chk("rst_valido",   {31'd0, valido},   32'd0);
    chk("rst_bcd",      {12'd0, reg_BCD},  32'd0);
    chk("rst_desborde", {31'd0, desborde}, 32'd0);
    chk("rst_negativo", {31'd0, negativo}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++)
      run_conv($sformatf("vec%0d", i), tbl[i].bin, tbl[i].bcd, tbl[i].neg);

    // Re-pulse of inicio while busy must be ignored.
    start_conv(16'd1234);
    nv     = 0;
    lat_at = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (valido) nv++;
    end
    reg_binario = 16'd4321;
    inicio      = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    if (valido) nv++;
    for (int k = 6; k <= 26; k++) begin
      @(posedge clk); #1;
      if (valido) begin
        nv++;
        if (lat_at == 0) lat_at = k;
      end
    end
    chk("ignorado_pulsos",   nv,     32'd1);
    chk("ignorado_latencia", lat_at, 32'd17);
    chk("ignorado_bcd",      {12'd0, reg_BCD}, 32'h01234);

    // inicio held in the valido cycle starts the next conversion without a gap.
    start_conv(16'd55);
    wait_valido(lat, ocup);
    chk("b2b_lat1", lat, 32'd17);
    check_result("b2b1", 20'h00055, 1'b0);
    reg_binario = 16'd77;
    inicio      = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    chk("b2b_sin_hueco", {31'd0, ocupado}, 32'd1);
    wait_valido(lat, ocup);
    chk("b2b_lat2", lat, 32'd17);
    check_result("b2b2", 20'h00077, 1'b0);
    @(posedge clk); #1;

    // Reset mid-conversion aborts it.
    run_conv("pre_rst", 16'd9999, 20'h09999, 1'b0);
    start_conv(16'hFFFF);
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_ocupado",  {31'd0, ocupado},  32'd0);
    chk("abort_valido",   {31'd0, valido},   32'd0);
    chk("abort_bcd",      {12'd0, reg_BCD},  32'd0);
    chk("abort_desborde", {31'd0, desborde}, 32'd0);
    chk("abort_bcd4",     {16'd0, reg_BCD4}, 32'd0);
    nv = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valido || ocupado) nv++;
    end
    chk("abort_sin_valido", nv, 32'd0);
    run_conv("post_rst", 16'd42, 20'h00042, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
